ghostchip_sound_timer: RTL

Parametrised CHIP-8/XO-CHIP timer and audio unit for the ghostchip top level. It holds the delay timer (DT) and the sound timer (ST), and decrements both on each vsync rising edge. While ST is non-zero it drives the speaker from either a fixed legacy square tone or a CPU-loaded 1-bit audio pattern buffer played at a pitch-controlled rate. It sits between cpu (register writes) and the top-level spkr output.

---
 rtl/ghostchip_sound_timer.sv | 118 +++++++++++
 1 files changed

// File: rtl/ghostchip_sound_timer.sv
// CHIP-8/XO-CHIP delay/sound timers plus 1-bit speaker player (legacy square or pattern buffer).
// Writes visible next cycle, spkr lags the bit index by one clock; no backpressure, inputs always accepted.
module ghostchip_sound_timer #(
    parameter int PATTERN_BYTES = 16,
    parameter int BASE_DIV      = 1250,
    parameter int PITCH_STEP    = 16,
    parameter int PER_W         = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             vsync,
    input  logic                             dt_we,
    input  logic                             st_we,
    input  logic [7:0]                       timer_din,
    output logic [7:0]                       dt_value,
    output logic [7:0]                       st_value,
    output logic                             beep,
    input  logic                             mode,
    input  logic                             pat_we,
    input  logic [$clog2(PATTERN_BYTES)-1:0] pat_addr,
    input  logic [7:0]                       pat_din,
    input  logic                             pitch_we,
    input  logic [7:0]                       pitch_din,
    output logic                             spkr
);

    localparam int NB = PATTERN_BYTES * 8;
    localparam int IW = $clog2(NB);
    localparam logic [7:0] PITCH_RST = 8'd64;

    function automatic logic [PER_W-1:0] period_of(input logic [7:0] p);
        logic [PER_W-1:0] span;
        span = PER_W'(8'd255 - p);
        return PER_W'(BASE_DIV) + span * PER_W'(PITCH_STEP);
    endfunction

    logic             vsync_q;
    logic             tick;
    logic [7:0]       dt_q;
    logic [7:0]       st_q;
    logic [7:0]       pitch_q;
    logic [7:0]       pat_mem [PATTERN_BYTES];
    logic [IW-1:0]    bit_idx;
    logic [PER_W-1:0] per_cnt;
    logic             spkr_q;
    logic             st_active;
    logic             reload;
    logic [7:0]       cur_byte;
    logic             src_bit;

    // vsync_q resets high so a vsync already high at release is not a tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vsync_q <= 1'b1;
        else       vsync_q <= vsync;
    end

    assign tick = vsync & ~vsync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dt_q <= '0;
            st_q <= '0;
        end else begin
            if (dt_we)                      dt_q <= timer_din;
            else if (tick && dt_q != 8'd0)  dt_q <= dt_q - 8'd1;
            if (st_we)                      st_q <= timer_din;
            else if (tick && st_q != 8'd0)  st_q <= st_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         pitch_q <= PITCH_RST;
        else if (pitch_we) pitch_q <= pitch_din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PATTERN_BYTES; i++) pat_mem[i] <= '0;
        end else if (pat_we) begin
            pat_mem[pat_addr] <= pat_din;
        end
    end

    assign st_active = (st_q != 8'd0);
    assign reload    = (per_cnt <= PER_W'(1));

    // Bit 0 of the index is the MSB of byte 0; legacy tone is 0xF0 repeated
    always_comb begin
        cur_byte = pat_mem[bit_idx[IW-1:3]];
        src_bit  = mode ? cur_byte[~bit_idx[2:0]] : ~bit_idx[2];
    end

    // Idle player tracks the current pitch so the next ST load starts on a full bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_idx <= '0;
            per_cnt <= period_of(PITCH_RST);
            spkr_q  <= 1'b0;
        end else begin
            spkr_q <= st_active & src_bit;
            if (!st_active) begin
                bit_idx <= '0;
                per_cnt <= period_of(pitch_q);
            end else if (reload) begin
                bit_idx <= bit_idx + 1'b1;
                per_cnt <= period_of(pitch_q);
            end else begin
                per_cnt <= per_cnt - 1'b1;
            end
        end
    end

    assign dt_value = dt_q;
    assign st_value = st_q;
    assign beep     = st_active;
    assign spkr     = spkr_q;

endmodule
